// File: rtl/ikaopll_dac_seq.sv
// Slot sequencer and sample-egress controller for the IKAOPLL DAC stage.
// Drives per-slot timing strobes and buffers DAC samples in a 2-entry FIFO.
module ikaopll_dac_seq #(
    parameter int          CYCLES      = 24,
    parameter logic [31:0] MO_MASK_FM9 = 32'h0023_2323,
    parameter logic [31:0] MO_MASK_RHY = 32'h0003_2320,
    parameter logic [31:0] RO_MASK_RHY = 32'h0078_0001
) (
    input  logic               i_EMUCLK,
    input  logic               i_RST_n,
    input  logic               i_phi1_NCEN_n,
    input  logic               i_RHYTHM_REQ,
    input  logic               i_MUTE_REQ,
    input  logic               i_ACC_STRB,
    input  logic signed [12:0] i_ACC,
    input  logic               i_SMPL_READY,
    input  logic               i_OVF_CLR,
    output logic [4:0]         o_SLOT,
    output logic               o_CYCLE_00,
    output logic               o_MO_CTRL,
    output logic               o_RO_CTRL,
    output logic               o_INHIBIT_FDBK,
    output logic               o_DAC_EN,
    output logic               o_RHYTHM_EN,
    output logic               o_SMPL_VALID,
    output logic signed [12:0] o_SMPL,
    output logic               o_OVF
);

    localparam logic [4:0] LAST_SLOT = 5'(CYCLES - 1);

    logic       cen;
    logic [4:0] slot;
    logic       rhy;
    logic       mute;
    logic       dac_en;
    logic       mo_ctrl;
    logic       ro_ctrl;

    assign cen = ~i_phi1_NCEN_n;

    always_comb begin
        mo_ctrl = rhy ? MO_MASK_RHY[slot] : MO_MASK_FM9[slot];
        ro_ctrl = rhy & RO_MASK_RHY[slot];
    end

    // Mode and mute are only sampled on the last slot so a period never mixes modes.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            slot   <= 5'd0;
            rhy    <= 1'b0;
            mute   <= 1'b0;
            dac_en <= 1'b0;
        end else if (cen) begin
            dac_en <= (mo_ctrl | ro_ctrl) & ~mute;
            if (slot == LAST_SLOT) begin
                slot <= 5'd0;
                rhy  <= i_RHYTHM_REQ;
                mute <= i_MUTE_REQ;
            end else begin
                slot <= slot + 5'd1;
            end
        end
    end

    logic signed [12:0] ent0;
    logic signed [12:0] ent1;
    logic [1:0]         cnt;
    logic               strb_prev;
    logic               ovf;
    logic               push;
    logic               pop;

    assign push = i_ACC_STRB & ~strb_prev;
    assign pop  = (cnt != 2'd0) & i_SMPL_READY;

    // Shift-style FIFO: ent0 is always the head, ent1 only holds data when full.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            ent0      <= '0;
            ent1      <= '0;
            cnt       <= 2'd0;
            strb_prev <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            strb_prev <= i_ACC_STRB;
            if (pop) begin
                if (cnt == 2'd2) begin
                    ent0 <= ent1;
                end else if (push) begin
                    ent0 <= i_ACC;
                end
                if (push && cnt == 2'd2) begin
                    ent1 <= i_ACC;
                end
                if (!push) begin
                    cnt <= cnt - 2'd1;
                end
            end else if (push) begin
                if (cnt == 2'd0) begin
                    ent0 <= i_ACC;
                    cnt  <= 2'd1;
                end else if (cnt == 2'd1) begin
                    ent1 <= i_ACC;
                    cnt  <= 2'd2;
                end
            end
            if (push && !pop && cnt == 2'd2) begin
                ovf <= 1'b1;
            end else if (i_OVF_CLR) begin
                ovf <= 1'b0;
            end
        end
    end

    assign o_SLOT         = slot;
    assign o_CYCLE_00     = (slot == 5'd0);
    assign o_MO_CTRL      = mo_ctrl;
    assign o_RO_CTRL      = ro_ctrl;
    assign o_INHIBIT_FDBK = ~(mo_ctrl | ro_ctrl);
    assign o_DAC_EN       = dac_en;
    assign o_RHYTHM_EN    = rhy;
    assign o_SMPL_VALID   = (cnt != 2'd0);
    assign o_SMPL         = ent0;
    assign o_OVF          = ovf;

endmodule

// File: tb/tb_ikaopll_dac_seq.sv
// Bench for ikaopll_dac_seq: slot-list reference model plus a queue scoreboard
// for the egress FIFO, driven by directed and randomized stimulus.
module tb_ikaopll_dac_seq;

    logic               i_EMUCLK = 1'b0;
    logic               i_RST_n = 1'b0;
    logic               i_phi1_NCEN_n = 1'b1;
    logic               i_RHYTHM_REQ = 1'b0;
    logic               i_MUTE_REQ = 1'b0;
    logic               i_ACC_STRB = 1'b0;
    logic signed [12:0] i_ACC = '0;
    logic               i_SMPL_READY = 1'b0;
    logic               i_OVF_CLR = 1'b0;
    logic [4:0]         o_SLOT;
    logic               o_CYCLE_00;
    logic               o_MO_CTRL;
    logic               o_RO_CTRL;
    logic               o_INHIBIT_FDBK;
    logic               o_DAC_EN;
    logic               o_RHYTHM_EN;
    logic               o_SMPL_VALID;
    logic signed [12:0] o_SMPL;
    logic               o_OVF;

    int errors = 0;
    int checks = 0;

    ikaopll_dac_seq dut (
        .i_EMUCLK      (i_EMUCLK),
        .i_RST_n       (i_RST_n),
        .i_phi1_NCEN_n (i_phi1_NCEN_n),
        .i_RHYTHM_REQ  (i_RHYTHM_REQ),
        .i_MUTE_REQ    (i_MUTE_REQ),
        .i_ACC_STRB    (i_ACC_STRB),
        .i_ACC         (i_ACC),
        .i_SMPL_READY  (i_SMPL_READY),
        .i_OVF_CLR     (i_OVF_CLR),
        .o_SLOT        (o_SLOT),
        .o_CYCLE_00    (o_CYCLE_00),
        .o_MO_CTRL     (o_MO_CTRL),
        .o_RO_CTRL     (o_RO_CTRL),
        .o_INHIBIT_FDBK(o_INHIBIT_FDBK),
        .o_DAC_EN      (o_DAC_EN),
        .o_RHYTHM_EN   (o_RHYTHM_EN),
        .o_SMPL_VALID  (o_SMPL_VALID),
        .o_SMPL        (o_SMPL),
        .o_OVF         (o_OVF)
    );

    always #5 i_EMUCLK = ~i_EMUCLK;

    // Enable is low on one clock in four, changed just after the rising edge.
    int ph_cnt = 0;
    initial begin
        forever begin
            @(posedge i_EMUCLK);
            #1;
            ph_cnt++;
            i_phi1_NCEN_n = ((ph_cnt % 4) != 0);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit exp_mo(input int s, input bit r);
        if (r) return s inside {5, 8, 9, 13, 16, 17};
        return s inside {0, 1, 5, 8, 9, 13, 16, 17, 21};
    endfunction

    function automatic bit exp_ro(input int s, input bit r);
        return r && (s inside {0, 19, 20, 21, 22});
    endfunction

    // Reference model state describing the DUT between two rising edges.
    int m_slot = 0;
    bit m_rhy = 0;
    bit m_mute = 0;
    bit m_dac = 0;
    bit m_ovf = 0;
    bit m_prev = 0;
    int m_fifo[$];
    bit m_mo;
    bit m_ro;
    bit m_push;
    bit m_pop;

    // Monitor: compare on the falling edge, then advance the model for the next rising edge.
    always @(negedge i_EMUCLK) begin
        if (!i_RST_n) begin
            m_slot = 0; m_rhy = 0; m_mute = 0; m_dac = 0;
            m_ovf = 0; m_prev = 0; m_fifo.delete();
        end
        m_mo = exp_mo(m_slot, m_rhy);
        m_ro = exp_ro(m_slot, m_rhy);
        checkOutput("slot", int'(o_SLOT), m_slot);
        checkOutput("cycle00", int'(o_CYCLE_00), int'(m_slot == 0));
        checkOutput("mo_ctrl", int'(o_MO_CTRL), int'(m_mo));
        checkOutput("ro_ctrl", int'(o_RO_CTRL), int'(m_ro));
        checkOutput("inhibit", int'(o_INHIBIT_FDBK), int'(!(m_mo || m_ro)));
        checkOutput("dac_en", int'(o_DAC_EN), int'(m_dac));
        checkOutput("rhythm_en", int'(o_RHYTHM_EN), int'(m_rhy));
        checkOutput("smpl_valid", int'(o_SMPL_VALID), int'(m_fifo.size() > 0));
        checkOutput("ovf", int'(o_OVF), int'(m_ovf));
        if (m_fifo.size() > 0 && o_SMPL_VALID)
            checkOutput("smpl_head", int'(o_SMPL), m_fifo[0]);
        if (i_RST_n) begin
            if (!i_phi1_NCEN_n) begin
                m_dac = (m_mo || m_ro) && !m_mute;
                if (m_slot == 23) begin
                    m_rhy = i_RHYTHM_REQ;
                    m_mute = i_MUTE_REQ;
                end
                m_slot = (m_slot + 1) % 24;
            end
            m_push = i_ACC_STRB && !m_prev;
            m_prev = i_ACC_STRB;
            m_pop = (m_fifo.size() > 0) && i_SMPL_READY;
            if (m_pop) void'(m_fifo.pop_front());
            if (m_push && m_fifo.size() >= 2) begin
                m_ovf = 1;
            end else begin
                if (m_push) m_fifo.push_back(int'(i_ACC));
                if (i_OVF_CLR) m_ovf = 0;
            end
        end
    end

    task automatic applyStimulus(input bit strb, input logic signed [12:0] acc, input bit rdy,
                                 input bit clr, input bit rhy, input bit mute);
        @(posedge i_EMUCLK);
        #1;
        i_ACC_STRB = strb;
        i_ACC = acc;
        i_SMPL_READY = rdy;
        i_OVF_CLR = clr;
        i_RHYTHM_REQ = rhy;
        i_MUTE_REQ = mute;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, 1'b0, 1'b0, i_RHYTHM_REQ, i_MUTE_REQ);
    endtask

    task automatic pushSample(input logic signed [12:0] v, input bit rdy);
        applyStimulus(1'b1, v, rdy, 1'b0, i_RHYTHM_REQ, i_MUTE_REQ);
        applyStimulus(1'b1, v, 1'b0, 1'b0, i_RHYTHM_REQ, i_MUTE_REQ);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, i_RHYTHM_REQ, i_MUTE_REQ);
    endtask

    task automatic waitSlot(input int target);
        for (int i = 0; i < 400; i++) begin
            @(negedge i_EMUCLK);
            if (int'(o_SLOT) == target) return;
        end
        checkOutput("wait_slot_timeout", int'(o_SLOT), target);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_slot"}, int'(o_SLOT), 0);
        checkOutput({tag, "_cycle00"}, int'(o_CYCLE_00), 1);
        checkOutput({tag, "_mo"}, int'(o_MO_CTRL), 1);
        checkOutput({tag, "_ro"}, int'(o_RO_CTRL), 0);
        checkOutput({tag, "_inhibit"}, int'(o_INHIBIT_FDBK), 0);
        checkOutput({tag, "_dac_en"}, int'(o_DAC_EN), 0);
        checkOutput({tag, "_rhythm_en"}, int'(o_RHYTHM_EN), 0);
        checkOutput({tag, "_valid"}, int'(o_SMPL_VALID), 0);
        checkOutput({tag, "_smpl"}, int'(o_SMPL), 0);
        checkOutput({tag, "_ovf"}, int'(o_OVF), 0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge i_EMUCLK);
        #2;
        checkResetValues("por");
        @(posedge i_EMUCLK);
        #1;
        i_RST_n = 1'b1;

        // Two FM9 periods, then rhythm requested mid-period, then mute mid-period.
        idle(2 * 24 * 4);
        waitSlot(10);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2 * 24 * 4);
        waitSlot(7);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2 * 24 * 4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2 * 24 * 4);

        // Overflow on a third sample, then drain.
        pushSample(13'h0FFF, 1'b0);
        pushSample(13'h1000, 1'b0);
        pushSample(13'h0005, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0, i_RHYTHM_REQ, i_MUTE_REQ);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, i_RHYTHM_REQ, i_MUTE_REQ);
        idle(2);

        // Push and pop together while full.
        pushSample(13'h0123, 1'b0);
        pushSample(13'h0234, 1'b0);
        pushSample(13'h1345, 1'b1);
        idle(3);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, i_RHYTHM_REQ, i_MUTE_REQ);
        idle(2);

        // Randomized traffic and mode requests.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) < 3), 13'($urandom), $urandom_range(0, 1) == 1,
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 99) == 0) ? ~i_RHYTHM_REQ : i_RHYTHM_REQ,
                          ($urandom_range(0, 99) == 0) ? ~i_MUTE_REQ : i_MUTE_REQ);
        end

        // Reset mid-period with one sample buffered and overflow set.
        repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        pushSample(13'h0011, 1'b0);
        pushSample(13'h0022, 1'b0);
        pushSample(13'h0033, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        waitSlot(15);
        #1;
        i_RST_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        idle(3);
        i_RST_n = 1'b1;
        idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ikaopll_dac_seq.md
# IKAOPLL_dac_seq

Slot sequencer and sample-egress controller for the IKAOPLL DAC stage. Runs the per-sample operator-slot counter. Generates the timing strobes the DAC consumes: cycle-0 marker, melody/rhythm output control, DAC enable and feedback inhibit. Switches rhythm mode and mute only on sample boundaries. Buffers the DAC's accumulated sample into a 2-entry valid/ready FIFO for the host audio path.

## Interface
- CYCLES, 24, slots per sample period; counter runs 0..CYCLES-1 (max 32).
- MO_MASK_FM9, 32'h0023_2323, melody-output slot mask in 9-channel FM mode (slots 0,1,5,8,9,13,16,17,21).
- MO_MASK_RHY, 32'h0003_2320, melody-output slot mask in rhythm mode (slots 5,8,9,13,16,17).
- RO_MASK_RHY, 32'h0078_0001, rhythm-output slot mask in rhythm mode (slots 0,19,20,21,22).

- i_EMUCLK  in  1  emulator master clock.
- i_RST_n  in  1  reset; **one clock; reset is asynchronous and active-low**.
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active low; all slot logic advances only on enabled edges.
- i_RHYTHM_REQ  in  1  requested rhythm mode (level).
- i_MUTE_REQ  in  1  requested mute (level).
- i_ACC_STRB  in  1  accumulated-sample strobe from DAC.
- i_ACC  in  13  signed accumulated sample from DAC.
- i_SMPL_READY  in  1  host accepts head sample.
- i_OVF_CLR  in  1  clears sticky overflow.
- o_SLOT  out  5  current slot number.
- o_CYCLE_00  out  1  high while o_SLOT==0.
- o_MO_CTRL  out  1  melody output slot.
- o_RO_CTRL  out  1  rhythm output slot.
- o_INHIBIT_FDBK  out  1  high on slots with neither MO nor RO.
- o_DAC_EN  out  1  impulse DAC enable.
- o_RHYTHM_EN  out  1  committed rhythm mode.
- o_SMPL_VALID  out  1  FIFO non-empty.
- o_SMPL  out  13  signed FIFO head.
- o_OVF  out  1  sticky overflow flag.

## Operation
- Slot counter: on each enabled edge, slot <= (slot==CYCLES-1) ? 0 : slot+1.
- Mode commit: on the enabled edge where slot==CYCLES-1, latch rhy <= i_RHYTHM_REQ and mute <= i_MUTE_REQ. Requests changing mid-period have no effect until the next boundary. Simultaneous change of both commits both together.
- o_MO_CTRL = (rhy ? MO_MASK_RHY : MO_MASK_FM9)[slot].
- o_RO_CTRL = rhy & RO_MASK_RHY[slot].
- o_INHIBIT_FDBK = ~(o_MO_CTRL | o_RO_CTRL). All three are combinational from registered slot and rhy.
- o_DAC_EN: registered on enabled edge as (o_MO_CTRL | o_RO_CTRL) & ~mute. This aligns with the DAC's one-tick-delayed control latch.
- Egress FIFO, 2 entries, runs on every i_EMUCLK edge, not gated by the enable:
  - A rising edge of i_ACC_STRB (registered-previous low, current high) pushes i_ACC.
  - A pop occurs when o_SMPL_VALID & i_SMPL_READY.
  - Push with pop on the same edge is allowed at any occupancy, including full.
  - Push when full without pop drops the new sample and sets o_OVF.
  - o_OVF clears on i_OVF_CLR; a simultaneous set wins.
- Mute does not gate the FIFO.

## Timing
- Reset values:
  - slot=0, so o_CYCLE_00=1.
  - rhy=0, so o_RHYTHM_EN=0, o_MO_CTRL=MO_MASK_FM9[0]=1, o_RO_CTRL=0, o_INHIBIT_FDBK=0.
  - mute=0, o_DAC_EN=0.
  - FIFO empty: o_SMPL_VALID=0, o_SMPL=0, o_OVF=0.
  - Strobe edge-detect register = 0.
- Reset asserted mid-period returns all state to the reset values immediately; the FIFO contents are lost.
- Slot outputs change only on enabled edges. o_DAC_EN lags o_MO_CTRL/o_RO_CTRL by exactly one enabled edge.
- Committed rhy/mute take effect from slot 0 of the next period.
- FIFO: push-to-valid latency is 1 i_EMUCLK edge. o_SMPL is stable while o_SMPL_VALID & ~i_SMPL_READY.
- A strobe held high for many clocks is one push. The strobe must return low before the next push.

## Test plan
- Reset release, enable every 4th clock, rhythm off: slot counts 0..23 then wraps to 0. o_MO_CTRL is high exactly at slots {0,1,5,8,9,13,16,17,21}. o_DAC_EN follows one enabled edge later.
- Raise i_RHYTHM_REQ at slot 10: o_RHYTHM_EN stays 0 through slot 23 and is 1 from slot 0. o_RO_CTRL is high at {0,19,20,21,22}. o_MO_CTRL at slot 21 = 0 and slot 1 = 0.
- i_MUTE_REQ=1 mid-period: o_DAC_EN is unaffected until the boundary, then 0 for the entire next period, while o_MO_CTRL keeps toggling.
- Three strobes with i_ACC = 13'sh0FFF, -4096, 5, i_SMPL_READY=0: FIFO holds 0x0FFF then -4096. The third sample is dropped and o_OVF=1. Assert ready: the bench reads 0x0FFF then -4096, then o_SMPL_VALID=0.
- Full FIFO with a strobe edge and ready on the same edge: no overflow, occupancy stays 2, and the new sample appears second.
- Assert i_RST_n=0 at slot 15 with the FIFO holding 1 entry and o_OVF=1: all outputs return to the reset values before the next clock edge.
